// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// alu_cmd_sequencer : command FIFO and registered issue/capture stage for
//                     alu_structural, with chained-operand forwarding.
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
    parameter int OPERATION = 3,
    parameter int WIDTH     = 8,
    parameter int SHIFT     = 3,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OPERATION-1:0] cmd_op,
    input  logic [SHIFT-1:0]     cmd_shamt,
    input  logic [WIDTH-1:0]     cmd_x,
    input  logic [WIDTH-1:0]     cmd_y,
    input  logic                 cmd_carry,
    input  logic                 cmd_chain,
    output logic [OPERATION-1:0] alu_operation,
    output logic [SHIFT-1:0]     alu_shamt,
    output logic [WIDTH-1:0]     alu_x,
    output logic [WIDTH-1:0]     alu_y,
    output logic                 alu_carry_in,
    output logic                 alu_busy,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH-1:0]     res_data,
    output logic                 res_zero,
    output logic                 res_overflow,
    input  logic                 clr_sticky,
    output logic                 sticky_ovf,
    output logic [CNT_W-1:0]     op_count
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [OPERATION-1:0] op;
        logic [SHIFT-1:0]     shamt;
        logic [WIDTH-1:0]     x;
        logic [WIDTH-1:0]     y;
        logic                 carry;
        logic                 chain;
    } cmd_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    cmd_t           fifo_mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q, count_d;
    state_t         state_q, state_d;
    logic [WIDTH-1:0] acc_q;

    logic           push, pop, cap, slot_free, empty, full;
    cmd_t           head;
    logic [WIDTH-1:0] x_sel;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_LVL);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign slot_free = !res_valid || res_ready;
    assign cap       = (state_q == S_EXEC) && slot_free;
    assign pop       = !empty && ((state_q == S_IDLE) || cap);
    assign alu_busy  = (state_q == S_EXEC);
    assign head      = fifo_mem_q[rd_ptr_q];

    // A chained command popped while the previous one is being captured
    // must see that result now; acc_q only catches up on this same edge.
    assign x_sel = !head.chain ? head.x :
                   (cap ? alu_result : acc_q);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop) state_d = S_EXEC;
            S_EXEC:  if (cap && !pop) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= '{op: cmd_op, shamt: cmd_shamt, x: cmd_x,
                                      y: cmd_y, carry: cmd_carry, chain: cmd_chain};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_operation <= '0;
            alu_shamt     <= '0;
            alu_x         <= '0;
            alu_y         <= '0;
            alu_carry_in  <= 1'b0;
        end else if (pop) begin
            alu_operation <= head.op;
            alu_shamt     <= head.shamt;
            alu_x         <= x_sel;
            alu_y         <= head.y;
            alu_carry_in  <= head.carry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_zero     <= 1'b0;
            res_overflow <= 1'b0;
            acc_q        <= '0;
            op_count     <= '0;
            sticky_ovf   <= 1'b0;
        end else begin
            if (cap) begin
                res_valid    <= 1'b1;
                res_data     <= alu_result;
                res_zero     <= alu_zero;
                res_overflow <= alu_overflow;
                acc_q        <= alu_result;
                op_count     <= op_count + CNT_W'(1);
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
            if (cap && alu_overflow) sticky_ovf <= 1'b1;
            else if (clr_sticky)     sticky_ovf <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// tb_alu_cmd_sequencer : directed, table-driven bench with a behavioural ALU.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op, cmd_shamt;
    logic [7:0] cmd_x, cmd_y;
    logic       cmd_carry, cmd_chain;
    logic [2:0] alu_operation, alu_shamt;
    logic [7:0] alu_x, alu_y;
    logic       alu_carry_in, alu_busy;
    logic [7:0] alu_result;
    logic       alu_zero, alu_overflow;
    logic       res_valid, res_ready;
    logic [7:0] res_data;
    logic       res_zero, res_overflow;
    logic       clr_sticky, sticky_ovf;
    logic [15:0] op_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_shamt(cmd_shamt), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_carry(cmd_carry), .cmd_chain(cmd_chain),
        .alu_operation(alu_operation), .alu_shamt(alu_shamt),
        .alu_x(alu_x), .alu_y(alu_y), .alu_carry_in(alu_carry_in),
        .alu_busy(alu_busy),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .res_overflow(res_overflow),
        .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .op_count(op_count)
    );

    // Stand-in ALU: 0 add, 1 sub, 2 and, 3 add+carry, 4 or, 5 xor, 6 shl, 7 shr
    always_comb begin
        alu_result   = 8'h00;
        alu_overflow = 1'b0;
        case (alu_operation)
            3'd0: begin
                alu_result   = alu_x + alu_y;
                alu_overflow = (alu_x[7] == alu_y[7]) && (alu_result[7] != alu_x[7]);
            end
            3'd1: begin
                alu_result   = alu_x - alu_y;
                alu_overflow = (alu_x[7] != alu_y[7]) && (alu_result[7] != alu_x[7]);
            end
            3'd2: alu_result = alu_x & alu_y;
            3'd3: begin
                alu_result   = alu_x + alu_y + {7'd0, alu_carry_in};
                alu_overflow = (alu_x[7] == alu_y[7]) && (alu_result[7] != alu_x[7]);
            end
            3'd4: alu_result = alu_x | alu_y;
            3'd5: alu_result = alu_x ^ alu_y;
            3'd6: alu_result = alu_x << alu_shamt;
            default: alu_result = alu_x >> alu_shamt;
        endcase
        alu_zero = (alu_result == 8'h00);
    end

    typedef struct {
        logic [2:0] op;
        logic [2:0] sh;
        logic [7:0] x;
        logic [7:0] y;
        logic       c;
        logic [7:0] d;
        logic       z;
        logic       v;
    } vec_t;

    vec_t tv [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] sh, input logic [7:0] x,
                         input logic [7:0] y, input logic c, input logic ch);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_shamt = sh;
        cmd_x     = x;
        cmd_y     = y;
        cmd_carry = c;
        cmd_chain = ch;
    endtask

    initial begin
        tv[0] = '{3'd3, 3'd0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0};
        tv[1] = '{3'd0, 3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tv[2] = '{3'd1, 3'd0, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[3] = '{3'd1, 3'd0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tv[4] = '{3'd2, 3'd0, 8'hF0, 8'h0F, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[5] = '{3'd5, 3'd0, 8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0, 1'b0};
        tv[6] = '{3'd6, 3'd3, 8'h13, 8'h00, 1'b0, 8'h98, 1'b0, 1'b0};
        tv[7] = '{3'd7, 3'd4, 8'hF0, 8'h00, 1'b0, 8'h0F, 1'b0, 1'b0};
        tv[8] = '{3'd4, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_shamt = '0; cmd_x = '0;
        cmd_y = '0; cmd_carry = 1'b0; cmd_chain = 1'b0; res_ready = 1'b1; clr_sticky = 1'b0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("rst_res_valid", res_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_op_count", op_count, 0);
        chk("rst_busy", alu_busy, 0);
        chk("rst_sticky", sticky_ovf, 0);

        // Single commands: accept, pop, capture, drain
        for (int i = 0; i < 9; i++) begin
            drive(tv[i].op, tv[i].sh, tv[i].x, tv[i].y, tv[i].c, 1'b0);
            step();
            cmd_valid = 1'b0;
            chk("busy_after_push", alu_busy, 0);
            step();
            chk("alu_x_issue", alu_x, tv[i].x);
            chk("busy_exec", alu_busy, 1);
            step();
            chk("res_valid_cap", res_valid, 1);
            chk("res_data", res_data, tv[i].d);
            chk("res_zero", res_zero, tv[i].z);
            chk("res_overflow", res_overflow, tv[i].v);
            step();
            chk("res_valid_drain", res_valid, 0);
            chk("busy_idle", alu_busy, 0);
        end
        chk("op_count_9", op_count, 9);
        chk("sticky_after_table", sticky_ovf, 1);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("sticky_cleared", sticky_ovf, 0);

        // Overflow capture and clear in the same cycle: set wins
        drive(3'd0, 3'd0, 8'h7F, 8'h01, 1'b0, 1'b0);
        step();
        cmd_valid = 1'b0;
        step();
        clr_sticky = 1'b1;
        step();
        chk("sticky_set_wins", sticky_ovf, 1);
        step();
        chk("sticky_clr_next", sticky_ovf, 0);
        clr_sticky = 1'b0;
        chk("op_count_10", op_count, 10);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_op_count", op_count, 0);
        chk("rst2_res_valid", res_valid, 0);

        // Four back-to-back commands: results on four consecutive cycles
        for (int i = 0; i < 4; i++) begin
            drive(3'd0, 3'd0, 8'(i + 1), 8'h10, 1'b0, 1'b0);
            step();
            chk("b2b_cmd_ready", cmd_ready, 1);
            if (i >= 2) chk("b2b_res", res_data, 32'h11 + 32'(i - 2));
        end
        cmd_valid = 1'b0;
        step();
        chk("b2b_res3", res_data, 8'h13);
        chk("b2b_valid3", res_valid, 1);
        step();
        chk("b2b_res4", res_data, 8'h14);
        chk("b2b_valid4", res_valid, 1);
        chk("b2b_op_count", op_count, 4);
        step();
        chk("b2b_drain", res_valid, 0);

        // Chain forwarding back-to-back, then chain from acc after a gap
        drive(3'd0, 3'd0, 8'h0F, 8'h01, 1'b0, 1'b0);
        step();
        drive(3'd0, 3'd0, 8'h00, 8'h01, 1'b0, 1'b1);
        step();
        cmd_valid = 1'b0;
        chk("chain_c1_x", alu_x, 8'h0F);
        step();
        chk("chain_c1_res", res_data, 8'h10);
        chk("chain_fwd_x", alu_x, 8'h10);
        step();
        chk("chain_c2_res", res_data, 8'h11);
        step(); step(); step();
        drive(3'd0, 3'd0, 8'h00, 8'h01, 1'b0, 1'b1);
        step();
        cmd_valid = 1'b0;
        step();
        chk("chain_acc_x", alu_x, 8'h11);
        step();
        chk("chain_acc_res", res_data, 8'h12);
        chk("chain_op_count", op_count, 7);
        step();

        // Backpressure: slot held, issue regs frozen, FIFO fills, nothing lost
        res_ready = 1'b0;
        drive(3'd0, 3'd0, 8'h20, 8'h01, 1'b0, 1'b0);
        step();
        drive(3'd0, 3'd0, 8'h30, 8'h01, 1'b0, 1'b0);
        step();
        cmd_valid = 1'b0;
        step();
        chk("stall_first_res", res_data, 8'h21);
        chk("stall_next_x", alu_x, 8'h30);
        for (int i = 0; i < 4; i++) begin
            drive(3'd0, 3'd0, 8'(8'h40 + 8'(16 * i)), 8'h01, 1'b0, 1'b0);
            step();
            chk("stall_alu_x", alu_x, 8'h30);
            chk("stall_res_data", res_data, 8'h21);
            chk("stall_res_valid", res_valid, 1);
        end
        cmd_valid = 1'b0;
        chk("full_cmd_ready", cmd_ready, 0);
        res_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("release_res", res_data, 32'h31 + 32'(16 * j));
            chk("release_valid", res_valid, 1);
        end
        chk("release_cmd_ready", cmd_ready, 1);
        step();
        chk("release_drain", res_valid, 0);

        // Reset while executing with a command still queued
        drive(3'd0, 3'd0, 8'h01, 8'h01, 1'b0, 1'b0);
        step();
        drive(3'd0, 3'd0, 8'h02, 8'h01, 1'b0, 1'b0);
        step();
        cmd_valid = 1'b0;
        chk("pre_rst_busy", alu_busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_busy", alu_busy, 0);
        chk("midrst_op_count", op_count, 0);
        chk("midrst_alu_x", alu_x, 0);
        step(); step(); step();
        chk("midrst_no_res", res_valid, 0);
        chk("midrst_fifo_empty", alu_busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
